// File: rtl/ot_pkg.sv
// ot_pkg -- definitions shared by the OT tree blocks.
//   reader_state_t : FSM states of the leaf reader
//   aw(d)          : buffer address width for a tree of depth d
//   DATA_W_DEFAULT : default width of one mB/msg buffer word
package ot_pkg;

    localparam int DATA_W_DEFAULT = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } reader_state_t;

    // A depth-d tree has 8 * 2**d leaf entries.
    function automatic int aw(input int d);
        return d + 3;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- small single-clock FIFO used as the reader's output buffer.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : write request and word; ignored when full unless a pop
//                       happens in the same cycle
//   pop               : read request; ignored when empty
//   head_data         : oldest word, driven from storage; zero while empty
//   full, empty       : status flags
//   occupancy         : number of stored words
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    occupancy
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        occupancy = count_q;
        do_pop    = pop && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push   = push && (!full || do_pop);
        wr_ptr_d  = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = do_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q + CW'(do_push) - CW'(do_pop);
        head_data = empty ? '0 : mem_q[rd_ptr_q];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the occupancy count already marks
    // every entry invalid, and head_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mb_leaf_reader.sv
// mb_leaf_reader -- streams a contiguous, wrapping address range of the
// mB/msg buffer out on a valid/ready interface after tree expansion.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : one-cycle request, accepted only in IDLE
//   base_addr, count      : first address and word count, latched on start
//   busy, done            : busy in RUN/DRAIN; done pulses once per transfer
//   mem_r_en, mem_r_addr  : buffer read port request
//   mem_r_data            : buffer read data, RD_LATENCY cycles after mem_r_en
//   out_valid, out_ready  : output stream handshake
//   out_data              : buffer word
//   out_index, out_last   : ordinal within the transfer and last-word flag
module mb_leaf_reader
    import ot_pkg::*;
#(
    parameter int D          = 3,
    parameter int TREE_SIZE  = 8 * (2 ** D),
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = RD_LATENCY + 2,
    localparam int AW        = aw(D)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [AW:0]       count,
    output logic              busy,
    output logic              done,
    output logic              mem_r_en,
    output logic [AW-1:0]     mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AW-1:0]     out_index,
    output logic              out_last
);

    localparam int          CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0] TREE_LIM = (AW + 1)'(TREE_SIZE);

    reader_state_t         state_q, state_d;
    logic [AW-1:0]         base_q, base_d;
    logic [AW:0]           count_q, count_d;
    logic [AW:0]           issued_q, issued_d;
    logic [AW:0]           emitted_q, emitted_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [RD_LATENCY-1:0] lat_sr_q, lat_sr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  rd_issue;
    logic                  credit_ok;
    logic [AW:0]           addr_sum;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_occ;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_r_data),
        .pop       (fifo_pop),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    always_comb begin
        // Every read in flight has a reserved FIFO slot, so returning data
        // always has somewhere to land regardless of backpressure.
        credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_occ}) < (CW + 1)'(FIFO_DEPTH);
        rd_issue  = (state_q == ST_RUN) && (issued_q < count_q) && credit_ok;
        fifo_push = lat_sr_q[RD_LATENCY-1];
        fifo_pop  = !fifo_empty && out_ready;

        // base < TREE_SIZE and issued < TREE_SIZE, so one subtraction wraps.
        addr_sum  = {1'b0, base_q} + {1'b0, issued_q[AW-1:0]};

        // NOTE: every next-state signal gets a default before the case so no
        // path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        issued_d   = issued_q + (AW + 1)'(rd_issue);
        emitted_d  = emitted_q + (AW + 1)'(fifo_pop);
        inflight_d = inflight_q + CW'(rd_issue) - CW'(fifo_push);
        lat_sr_d   = RD_LATENCY'({lat_sr_q, rd_issue});

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_RUN;
                        busy_d     = 1'b1;
                        base_d     = base_addr;
                        count_d    = count;
                        issued_d   = '0;
                        emitted_d  = '0;
                        inflight_d = '0;
                    end
                end
            end
            ST_RUN: begin
                if (rd_issue && (issued_d == count_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (emitted_d == count_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            emitted_q  <= '0;
            inflight_q <= '0;
            lat_sr_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            emitted_q  <= emitted_d;
            inflight_q <= inflight_d;
            lat_sr_q   <= lat_sr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_r_en   = rd_issue;
    assign mem_r_addr = (addr_sum >= TREE_LIM) ? AW'(addr_sum - TREE_LIM) : addr_sum[AW-1:0];
    assign out_valid  = !fifo_empty;
    assign out_index  = emitted_q[AW-1:0];
    assign out_last   = out_valid && (emitted_q == count_q - (AW + 1)'(1));

    // The credit check makes overflow impossible; a push into a full FIFO
    // without a simultaneous pop means a read was issued without a credit.
    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_mb_leaf_reader.sv
module tb_mb_leaf_reader;
    import ot_pkg::*;

    localparam int D     = 3;
    localparam int AW    = 6;
    localparam int TS    = 64;
    localparam int DW    = 128;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam logic [DW-1:0] GARBAGE = {4{32'hdeadbeef}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          out_ready;
    int            sel;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: RD_LATENCY=1, instance B: RD_LATENCY=3.
    logic          busy_a, done_a, en_a, valid_a, last_a;
    logic [AW-1:0] addr_a, idx_a;
    logic [DW-1:0] rdata_a, data_a;
    logic          busy_b, done_b, en_b, valid_b, last_b;
    logic [AW-1:0] addr_b, idx_b;
    logic [DW-1:0] rdata_b, data_b;

    mb_leaf_reader #(.D(D), .RD_LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start && sel == 0), .base_addr(base_addr),
        .count(count), .busy(busy_a), .done(done_a), .mem_r_en(en_a),
        .mem_r_addr(addr_a), .mem_r_data(rdata_a), .out_valid(valid_a),
        .out_ready(sel == 0 ? out_ready : 1'b1), .out_data(data_a),
        .out_index(idx_a), .out_last(last_a)
    );

    mb_leaf_reader #(.D(D), .RD_LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start && sel == 1), .base_addr(base_addr),
        .count(count), .busy(busy_b), .done(done_b), .mem_r_en(en_b),
        .mem_r_addr(addr_b), .mem_r_data(rdata_b), .out_valid(valid_b),
        .out_ready(sel == 1 ? out_ready : 1'b1), .out_data(data_b),
        .out_index(idx_b), .out_last(last_b)
    );

    // Buffer model: data appears exactly RD_LATENCY cycles after the strobe,
    // garbage otherwise, so a mistimed push captures a wrong word.
    logic [DW-1:0] mem [TS];
    bit [AW-1:0] pa_addr [LAT_A];
    bit          pa_en   [LAT_A];
    bit [AW-1:0] pb_addr [LAT_B];
    bit          pb_en   [LAT_B];

    always @(posedge clk) begin
        for (int i = LAT_A - 1; i > 0; i--) begin
            pa_addr[i] <= pa_addr[i-1];
            pa_en[i]   <= pa_en[i-1];
        end
        pa_addr[0] <= addr_a;
        pa_en[0]   <= (en_a === 1'b1);
    end

    always @(posedge clk) begin
        for (int j = LAT_B - 1; j > 0; j--) begin
            pb_addr[j] <= pb_addr[j-1];
            pb_en[j]   <= pb_en[j-1];
        end
        pb_addr[0] <= addr_b;
        pb_en[0]   <= (en_b === 1'b1);
    end

    assign rdata_a = pa_en[LAT_A-1] ? mem[pa_addr[LAT_A-1]] : GARBAGE;
    assign rdata_b = pb_en[LAT_B-1] ? mem[pb_addr[LAT_B-1]] : GARBAGE;

    // Observed outputs of the instance under test.
    logic          o_busy, o_done, o_en, o_valid, o_last;
    logic [AW-1:0] o_addr, o_index;
    logic [DW-1:0] o_data;

    always_comb begin
        if (sel == 0) begin
            o_busy = busy_a; o_done = done_a; o_en = en_a; o_addr = addr_a;
            o_valid = valid_a; o_data = data_a; o_index = idx_a; o_last = last_a;
        end else begin
            o_busy = busy_b; o_done = done_b; o_en = en_b; o_addr = addr_b;
            o_valid = valid_b; o_data = data_b; o_index = idx_b; o_last = last_b;
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  o_busy,  0);
        check({tag, "_done"},  o_done,  0);
        check({tag, "_en"},    o_en,    0);
        check({tag, "_addr"},  o_addr,  0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_data"},  o_data,  0);
        check({tag, "_index"}, o_index, 0);
        check({tag, "_last"},  o_last,  0);
    endtask

    // One transfer on instance s: n words from base b. out_ready is high with
    // probability ready_pct%, and forced low for stall_len cycles from cycle
    // stall_at. Cycle 0 is the cycle in which start is sampled.
    task automatic run_xfer(input int s, input int b, input int n, input int ready_pct,
                            input int stall_at, input int stall_len);
        int lat, depth, issued, emitted, first_en, first_v, last_beat, done_c;
        bit all_ready, prev_stall;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] prev_index;
        logic          prev_last;
        logic [DW-1:0] exp_q [$];

        lat = (s == 0) ? LAT_A : LAT_B;
        depth = lat + 2;
        issued = 0; emitted = 0; first_en = -1; first_v = -1; last_beat = -1; done_c = -1;
        all_ready = (ready_pct >= 100) && (stall_len == 0);
        prev_stall = 1'b0; prev_data = '0; prev_index = '0; prev_last = 1'b0;
        for (int k = 0; k < n; k++) exp_q.push_back(mem[(b + k) % TS]);

        @(posedge clk); #2;
        sel = s; start = 1'b1; base_addr = AW'(b); count = (AW + 1)'(n); out_ready = 1'b0;

        for (int c = 1; c <= 600 && done_c < 0; c++) begin
            @(posedge clk); #2;
            // Inputs outside an accepted start must have no effect.
            start     = 1'($urandom_range(1));
            base_addr = AW'($urandom);
            count     = (AW + 1)'($urandom);
            if (c >= stall_at && c < stall_at + stall_len) out_ready = 1'b0;
            else out_ready = ($urandom_range(99) < ready_pct);
            #1;

            if (o_en === 1'b1) begin
                check("rd_addr", o_addr, (b + issued) % TS);
                if (first_en < 0) first_en = c;
                issued++;
            end
            check("credit", (issued - emitted) <= depth, 1);
            if (prev_stall) begin
                check("stall_valid", o_valid, 1);
                check("stall_data",  o_data,  prev_data);
                check("stall_index", o_index, prev_index);
                check("stall_last",  o_last,  prev_last);
            end
            if (o_valid === 1'b1 && first_v < 0) first_v = c;
            if (all_ready && first_v >= 0 && emitted < n) check("no_bubble", o_valid, 1);
            if (o_valid === 1'b1 && out_ready) begin
                check("beat_in_range", emitted < n, 1);
                if (emitted < n) begin
                    check("beat_data",  o_data,  exp_q[emitted]);
                    check("beat_index", o_index, emitted);
                    check("beat_last",  o_last,  emitted == n - 1);
                end
                emitted++;
                last_beat = c;
            end
            if (o_done === 1'b1) begin
                done_c = c;
                check("busy_at_done", o_busy, 0);
            end else begin
                check("busy_during", o_busy, 1);
            end
            prev_stall = (o_valid === 1'b1) && !out_ready;
            prev_data = o_data; prev_index = o_index; prev_last = o_last;
        end
        start = 1'b0;

        check("done_seen", done_c >= 0, 1);
        check("issued_total", issued, n);
        check("emitted_total", emitted, n);
        if (n == 0) begin
            check("zero_done_cycle", done_c, 1);
            check("zero_no_valid", first_v < 0, 1);
        end else begin
            check("first_rd_cycle", first_en, 1);
            check("first_valid_cycle", first_v, 2 + lat);
            check("done_after_last", done_c, last_beat + 1);
            if (all_ready) check("total_cycles", done_c, n + 2 + lat);
        end
    endtask

    initial begin
        int issued;

        rst = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0; sel = 0;
        for (int a = 0; a < TS; a++) mem[a] = DW'(32'h100 + a);

        #2 rst = 1'b1;
        #3;
        check_reset_outputs("rst_a");
        sel = 1; #1;
        check_reset_outputs("rst_b");
        sel = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Basic and wrap on RD_LATENCY=1 with preloaded addr+0x100.
        run_xfer(0, 0, 8, 100, 0, 0);
        run_xfer(0, 60, 8, 100, 0, 0);

        for (int a = 0; a < TS; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};

        // Backpressure: random 30% ready with a 20-cycle stall mid-stream.
        run_xfer(0, $urandom_range(TS - 1), 16, 30, 6, 20);
        run_xfer(1, $urandom_range(TS - 1), 16, 30, 6, 20);

        // Zero count.
        run_xfer(0, 5, 0, 100, 0, 0);

        // Full tree at RD_LATENCY=3, restarted right after done.
        run_xfer(1, 0, 64, 100, 0, 0);
        run_xfer(1, $urandom_range(TS - 1), 64, 100, 0, 0);

        // Reset abort with 5 reads in flight on RD_LATENCY=3.
        @(posedge clk); #2;
        sel = 1; start = 1'b1; base_addr = AW'(7); count = (AW + 1)'(20); out_ready = 1'b0;
        issued = 0;
        for (int c = 1; c <= 20 && issued < 5; c++) begin
            @(posedge clk); #2;
            start = 1'b0;
            #1;
            if (o_en === 1'b1) issued++;
        end
        check("abort_issued", issued, 5);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #3;
            check("post_abort_valid", o_valid, 0);
            check("post_abort_en", o_en, 0);
            check("post_abort_busy", o_busy, 0);
        end
        run_xfer(1, 30, 4, 100, 0, 0);

        // A few random transfers on both instances.
        for (int t = 0; t < 6; t++) begin
            run_xfer(t % 2, $urandom_range(TS - 1), $urandom_range(TS, 1),
                     $urandom_range(100, 20), $urandom_range(30, 4), $urandom_range(6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
